// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and state type for the load/store unit
package lsu_pkg;

  localparam int MEM_WORDS_DEFAULT = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    RESP
  } state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - cpu request/response and data_memory port bundle
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_write_enable, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_write_enable, mem_address, mem_write_data
  );

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extraction/extension and store-lane merge
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed byte and halfword lanes of the fetched word
  always_comb begin
    byte_lane = rd_word[7:0];
    case (addr_lo)
      2'd1:    byte_lane = rd_word[15:8];
      2'd2:    byte_lane = rd_word[23:16];
      2'd3:    byte_lane = rd_word[31:24];
      default: byte_lane = rd_word[7:0];
    endcase
    half_lane = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
  end

  // Sign- or zero-extend the selected lane according to the access size
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'd0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'd0, half_lane};
      F3_W:    load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  // Overlay the low store bits onto the target lane of the old word
  always_comb begin
    merged_word = wdata;
    case (funct3)
      F3_B, F3_BU: begin
        merged_word = rd_word;
        case (addr_lo)
          2'd1:    merged_word[15:8]  = wdata[7:0];
          2'd2:    merged_word[23:16] = wdata[7:0];
          2'd3:    merged_word[31:24] = wdata[7:0];
          default: merged_word[7:0]   = wdata[7:0];
        endcase
      end
      F3_H, F3_HU: begin
        merged_word = rd_word;
        if (addr_lo[1]) merged_word[31:16] = wdata[15:0];
        else            merged_word[15:0]  = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - cpu load/store requests to data_memory accesses with rmw sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  load_store_unit_if.slave    bus
);

  localparam logic [31:0] RANGE_LIMIT = 32'(MEM_WORDS * 4);

  state_t      state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        misaligned;
  logic        funct3_illegal;
  logic        req_err;

  lsu_lane_align u_lane_align (
    .addr_lo     (addr_lo_q),
    .funct3      (funct3_q),
    .rd_word     (bus.mem_read_data),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Classify the incoming request as legal or erroneous
  always_comb begin
    misaligned     = 1'b0;
    funct3_illegal = 1'b0;
    case (bus.req_funct3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = bus.req_addr[0];
      F3_W:        misaligned = |bus.req_addr[1:0];
      default:     funct3_illegal = 1'b1;
    endcase
    // unsigned sizes only make sense for loads
    req_err = funct3_illegal | misaligned | (bus.req_addr >= RANGE_LIMIT)
            | (bus.req_we & bus.req_funct3[2]);
  end

  // Next state and next values of the registered datapath
  always_comb begin
    state_d       = state_q;
    addr_lo_d     = addr_lo_q;
    funct3_d      = funct3_q;
    wdata_d       = wdata_q;
    mem_address_d = mem_address_q;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_lo_d    = bus.req_addr[1:0];
          funct3_d     = bus.req_funct3;
          wdata_d      = bus.req_wdata;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          if (req_err) begin
            resp_err_d = 1'b1;
            state_d    = RESP;
          end else begin
            mem_address_d = {2'b00, bus.req_addr[31:2]};
            if (!bus.req_we)                   state_d = LOAD;
            else if (bus.req_funct3 == F3_W)   state_d = WRITE;
            else                               state_d = RMW_READ;
          end
        end
      end
      LOAD: begin
        resp_rdata_d = load_data;
        state_d      = RESP;
      end
      RMW_READ: begin
        wdata_d = merged_word;
        state_d = WRITE;
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_lo_q     <= '0;
      funct3_q      <= '0;
      wdata_q       <= '0;
      mem_address_q <= '0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_lo_q     <= addr_lo_d;
      funct3_q      <= funct3_d;
      wdata_q       <= wdata_d;
      mem_address_q <= mem_address_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign bus.req_ready        = (state_q == IDLE);
  assign bus.resp_valid       = (state_q == RESP);
  assign bus.resp_rdata       = resp_rdata_q;
  assign bus.resp_err         = resp_err_q;
  // a reset seen during the write cycle must not corrupt memory
  assign bus.mem_write_enable = (state_q == WRITE) & ~reset;
  assign bus.mem_address      = mem_address_q;
  assign bus.mem_write_data   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // data_memory: combinational read, write on the rising edge
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        wr_pend;
  logic [31:0] wr_addr, wr_data;

  assign bus.mem_read_data = (bus.mem_address < 32'd64) ? mem[bus.mem_address[5:0]] : 32'd0;

  always @(negedge clk) begin
    wr_pend = bus.mem_write_enable;
    wr_addr = bus.mem_address;
    wr_data = bus.mem_write_data;
  end

  always @(posedge clk) begin
    if (wr_pend && wr_addr < 32'd64) mem[wr_addr[5:0]] = wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // transaction-level model state
  bit          busy = 1'b0;
  int          k = 0;
  int          lat_m = 1;
  bit          m_we = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_idx = '0;
  logic [31:0] m_new = '0;

  logic        p_req_valid = 1'b0;
  logic        p_we = 1'b0;
  logic [2:0]  p_f3 = '0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_wdata = '0;
  logic        p_resp_ready = 1'b0;
  logic        p_reset = 1'b1;

  always @(negedge clk) begin : model
    int          size;
    bit          legal;
    logic [1:0]  off;
    logic [31:0] word, v, mask;
    bit          e_we;

    if (p_reset) begin
      busy = 1'b0;
    end else if (busy) begin
      if (m_we && !m_err && k == lat_m - 1) ref_mem[m_idx[5:0]] = m_new;
      if (k >= lat_m && p_resp_ready) busy = 1'b0;
      else if (k < lat_m) k++;
    end else if (p_req_valid) begin
      legal = 1'b1;
      case (p_f3)
        3'b000, 3'b100: size = 1;
        3'b001, 3'b101: size = 2;
        3'b010:         size = 4;
        default: begin size = 1; legal = 1'b0; end
      endcase
      m_err = !legal || (p_we && p_f3[2]) || ((p_addr & 32'(size - 1)) != 0) || (p_addr >= 32'd256);
      m_idx = p_addr >> 2;
      off   = p_addr[1:0];
      word  = m_err ? 32'd0 : ref_mem[m_idx[5:0]];
      v     = word >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (!p_f3[2] && v >= 32'd128) v = v - 32'd256;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (!p_f3[2] && v >= 32'd32768) v = v - 32'd65536;
      end
      m_rdata = (m_err || p_we) ? 32'd0 : v;
      mask  = (size == 4) ? 32'hFFFFFFFF : (((32'd1 << (8 * size)) - 32'd1) << (8 * off));
      m_new = (word & ~mask) | ((p_wdata << (8 * off)) & mask);
      lat_m = m_err ? 1 : (!p_we ? 2 : (size == 4 ? 2 : 3));
      m_we  = p_we;
      busy  = 1'b1;
      k     = 1;
    end

    chk("req_ready", 32'(bus.req_ready), 32'(!busy));
    chk("resp_valid", 32'(bus.resp_valid), 32'(busy && k >= lat_m));
    if (busy && k >= lat_m) begin
      chk("resp_rdata", bus.resp_rdata, m_rdata);
      chk("resp_err", 32'(bus.resp_err), 32'(m_err));
    end
    e_we = busy && m_we && !m_err && (k == lat_m - 1) && !reset;
    chk("mem_write_enable", 32'(bus.mem_write_enable), 32'(e_we));
    if (busy && !m_err && k < lat_m) chk("mem_address", bus.mem_address, m_idx);
    if (e_we) chk("mem_write_data", bus.mem_write_data, m_new);

    p_req_valid  = bus.req_valid;
    p_we         = bus.req_we;
    p_f3         = bus.req_funct3;
    p_addr       = bus.req_addr;
    p_wdata      = bus.req_wdata;
    p_resp_ready = bus.resp_ready;
    p_reset      = reset;
  end

  // issue one request from posedge+2; optionally hold off the response
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (!bus.req_ready) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin @(posedge clk); #2; lat++; end
    if (!bus.resp_valid) chk("resp_valid_timeout", 32'(bus.resp_valid), 32'd1);
    rd = bus.resp_rdata;
    er = bus.resp_err;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'hDEADBEEF;
      end
      @(posedge clk); #2;
      bus.req_valid = 1'b0;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #2;
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] rd;
    logic        er;
    int          lat;

    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem[5] = 32'h11223344;
    ref_mem[5] = 32'h11223344;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset_resp_rdata", bus.resp_rdata, 32'd0);
    chk("reset_resp_err", 32'(bus.resp_err), 32'd0);
    chk("reset_mem_we", 32'(bus.mem_write_enable), 32'd0);
    chk("reset_mem_address", bus.mem_address, 32'd0);
    chk("reset_mem_write_data", bus.mem_write_data, 32'd0);

    do_req(1'b1, F3_W, 32'h0C, 32'd45, 0, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_err", 32'(er), 32'd0);
    do_req(1'b0, F3_W, 32'h0C, 32'd0, 0, rd, er, lat);
    chk("lw_rdata", rd, 32'd45);
    chk("lw_lat", 32'(lat), 32'd2);

    do_req(1'b1, F3_B, 32'h15, 32'hAA, 0, rd, er, lat);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_word5", mem[5], 32'h1122AA44);
    do_req(1'b0, F3_B, 32'h15, 32'd0, 0, rd, er, lat);
    chk("lb_rdata", rd, 32'hFFFFFFAA);
    do_req(1'b0, F3_BU, 32'h15, 32'd0, 0, rd, er, lat);
    chk("lbu_rdata", rd, 32'h000000AA);

    do_req(1'b1, F3_W, 32'h0C, 32'h80010000, 0, rd, er, lat);
    do_req(1'b0, F3_H, 32'h0E, 32'd0, 0, rd, er, lat);
    chk("lh_rdata", rd, 32'hFFFF8001);
    do_req(1'b0, F3_HU, 32'h0E, 32'd0, 0, rd, er, lat);
    chk("lhu_rdata", rd, 32'h00008001);
    do_req(1'b1, F3_H, 32'h0C, 32'h00001234, 0, rd, er, lat);
    chk("sh_lat", 32'(lat), 32'd3);
    do_req(1'b0, F3_W, 32'h0C, 32'd0, 0, rd, er, lat);
    chk("sh_word3", rd, 32'h80011234);

    do_req(1'b0, F3_W, 32'h06, 32'd0, 0, rd, er, lat);
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
    chk("lw_mis_lat", 32'(lat), 32'd1);
    do_req(1'b1, F3_W, 32'h100, 32'h12345678, 0, rd, er, lat);
    chk("sw_oor_err", 32'(er), 32'd1);
    do_req(1'b1, F3_BU, 32'h08, 32'hFF, 0, rd, er, lat);
    chk("st_illegal_err", 32'(er), 32'd1);
    do_req(1'b0, 3'b011, 32'h08, 32'd0, 0, rd, er, lat);
    chk("ld_f3_011_err", 32'(er), 32'd1);
    do_req(1'b0, F3_HU, 32'h0D, 32'd0, 0, rd, er, lat);
    chk("lhu_mis_err", 32'(er), 32'd1);
    do_req(1'b0, F3_BU, 32'hFF, 32'd0, 0, rd, er, lat);
    chk("lbu_last_byte_ok", 32'(er), 32'd0);

    do_req(1'b0, F3_W, 32'h14, 32'd0, 3, rd, er, lat);
    chk("bp_rdata", rd, 32'h1122AA44);
    chk("bp_word0_untouched", mem[0], 32'd0);

    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h15;
    bus.req_wdata  = 32'h55;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #2;
    chk("rst_word5", mem[5], 32'h1122AA44);
    do_req(1'b0, F3_BU, 32'h15, 32'd0, 0, rd, er, lat);
    chk("rst_lbu", rd, 32'h000000AA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
